// File: rtl/rom_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter_if
//
// Bundles the two requester channels and the single-port block ROM signals
// that the rom_read_arbiter sits between.
//
// Signals:
//   req0_valid / req0_addr / req0_ready : port 0 request handshake
//   rsp0_valid / rsp0_data              : port 0 read response
//   req1_valid / req1_addr / req1_ready : port 1 request handshake
//   rsp1_valid / rsp1_data              : port 1 read response
//   ram_addr / ram_en / ram_regce       : ROM address, enable, output reg enable
//   ram_dout                            : ROM data output
//
// Modports:
//   slave  : the arbiter's view (takes requests and ROM data, drives the rest)
//   master : the environment's view (requesters plus the ROM)
// ---------------------------------------------------------------------------
interface rom_read_arbiter_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
);
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic                  req0_ready;
    logic                  rsp0_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;

    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic                  req1_ready;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp1_data;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_en;
    logic                  ram_regce;
    logic [DATA_WIDTH-1:0] ram_dout;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, ram_dout,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output ram_addr, ram_en, ram_regce
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, ram_dout,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  ram_addr, ram_en, ram_regce
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares one single-port block ROM between two independent read requesters.
// At most one read is issued per cycle. Every issued read carries a tag
// through a LATENCY-deep pipeline, so the returning ROM data is flagged valid
// for the port that asked for it. Responses come back in issue order with no
// back-pressure.
//
// Parameters:
//   ADDR_WIDTH : ROM address width (default 13, 8192 entries)
//   DATA_WIDTH : ROM data width (default 16)
//   LATENCY    : ROM read latency in clock edges, 1 or 2
//
// Ports:
//   clk : single clock, shared with the ROM
//   rst : asynchronous, active-high reset
//   bus : rom_read_arbiter_if.slave (request/response channels + ROM drive)
//
// Configuration macro:
//   ROM_ARB_FIXED_PRIO_EN : when defined, port 0 always wins a collision and
//                           the round-robin pointer is not built. When
//                           undefined (default), grants alternate round-robin.
// ---------------------------------------------------------------------------
module rom_read_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input logic              clk,
    input logic              rst,
    rom_read_arbiter_if.slave bus
);

    logic                  grant0;
    logic                  grant1;
    logic                  anyGrant;
    logic [ADDR_WIDTH-1:0] grantAddr;
    logic [DATA_WIDTH-1:0] romData;

    // Stage i holds {valid, port} of the read issued i+1 edges ago.
    logic [LATENCY-1:0] tagValid_q;
    logic [LATENCY-1:0] tagPort_q;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // Port 0 always wins; port 1 only gets the ROM when port 0 is quiet.
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    logic prio_q;
    logic prio_d;

    // On a collision the port named by prio_q wins; otherwise the lone
    // requester wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant0 = ~prio_q;
            grant1 = prio_q;
        end else begin
            grant0 = bus.req0_valid;
            grant1 = bus.req1_valid;
        end
    end

    // Priority always moves to the port that was not granted. On a collision
    // that is the same as flipping the pointer.
    always_comb begin
        prio_d = prio_q;
        if (grant0) begin
            prio_d = 1'b1;
        end else if (grant1) begin
            prio_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign anyGrant = grant0 | grant1;

    // Address mux. It drives 0 when idle so the ROM address bus stays quiet.
    always_comb begin
        grantAddr = '0;
        if (grant1) begin
            grantAddr = bus.req1_addr;
        end else if (grant0) begin
            grantAddr = bus.req0_addr;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.ram_addr   = grantAddr;
    assign bus.ram_en     = bus.req0_valid | bus.req1_valid;
    assign bus.ram_regce  = 1'b1;

    // The tag pipeline shifts every cycle with no stall, so tags stay in step
    // with data moving through the ROM's fixed-latency read path. Reset drops
    // any reads in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValid_q <= '0;
            tagPort_q  <= '0;
        end else begin
            tagValid_q[0] <= anyGrant;
            tagPort_q[0]  <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagPort_q[i]  <= tagPort_q[i-1];
            end
        end
    end

    // Both ports see the raw ROM output. The last tag stage says whose it is.
    assign romData        = bus.ram_dout;
    assign bus.rsp0_data  = romData;
    assign bus.rsp1_data  = romData;
    assign bus.rsp0_valid = tagValid_q[LATENCY-1] & ~tagPort_q[LATENCY-1];
    assign bus.rsp1_valid = tagValid_q[LATENCY-1] &  tagPort_q[LATENCY-1];

endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Shares one single-port block ROM (read-only BRAM, 1- or 2-cycle read latency) between two independent read requesters, e.g. the OLED pixel fetcher and the game/sprite logic. Issues at most one read per cycle, with round-robin arbitration and full pipelining. It tags each issued read, so the returning data is routed to the requester that asked for it. It sits directly in front of the ROM, drives its address, enable and output-register-enable, and takes its data output.

## Interface
Parameters:
- ADDR_WIDTH, 13: ROM address width; 8192 entries.
- DATA_WIDTH, 16: ROM data width.
- LATENCY, 2: ROM read latency in clock edges. Legal values are 1 (no output register) and 2 (output register).

Ports:
- clk  in  1  Single clock; the ROM shares it.
- rst  in  1  Asynchronous, active-high reset.
- req0_valid  in  1  Port 0 requests a read.
- req0_addr  in  ADDR_WIDTH  Port 0 read address.
- req0_ready  out  1  Port 0 request accepted this cycle.
- rsp0_valid  out  1  Port 0 read data valid.
- rsp0_data  out  DATA_WIDTH  Port 0 read data.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as port 0, for port 1.
- ram_addr  out  ADDR_WIDTH  ROM address.
- ram_en  out  1  ROM enable.
- ram_regce  out  1  ROM output register enable.
- ram_dout  in  DATA_WIDTH  ROM data output.

## Operation
**Request handshake**
- A request is accepted on a rising edge where reqN_valid and reqN_ready are both 1.
- reqN_ready is combinational from the valid inputs and the priority pointer.
- A requester must hold valid and addr stable until it is accepted.

**Arbitration**
- When only one port is valid, that port is granted.
- When both ports are valid, the port named by the pointer `prio` is granted.
- After a grant with both ports valid, `prio` flips to the other port.
- After a grant to a single port, `prio` moves to the port that was not granted.
- With no grant, `prio` holds.
- Exactly one reqN_ready is 1 whenever any reqN_valid is 1. No grant is given when no port is valid.

**ROM drive**
- ram_en = req0_valid | req1_valid.
- ram_addr = the granted port's address, or 0 when idle.
- ram_regce = 1, constant.

**Tag pipeline**
- A LATENCY-deep shift register holds {valid, port} for each issued read.
- Stage 0 is loaded at the accept edge. All stages shift every cycle, with no stall.
- The last stage drives rspN_valid = stage.valid & (stage.port == N).
- rspN_data = ram_dout for both ports. Data is meaningful only while the matching rspN_valid is high.

**Back-pressure and ordering**
- There is no response back-pressure: a requester must accept data in the cycle its rspN_valid is high.
- Responses return in issue order. Throughput is 1 read per cycle in aggregate.

**Reset**
- Reset clears all pipeline stages and sets `prio` to port 0.
- Any read in flight when reset asserts is dropped; no rsp is generated for it.

## Timing
- Reset values:
  - rsp0_valid = rsp1_valid = 0.
  - `prio` = 0.
  - ram_en, reqN_ready and ram_addr follow the inputs combinationally; all are 0 while both valids are 0.
- Latency: a request accepted at edge E produces rspN_valid high during the cycle after edge E+LATENCY-1. That is LATENCY cycles after the accept cycle, aligned with the ROM's douta.
- Back-to-back reads:
  - Accepts in consecutive cycles produce responses in consecutive cycles, in the same order.
  - Alternating ports under contention yields 0,1,0,1,…
- Simultaneous first request after reset: port 0 wins.
- Reset deasserted mid-stream: rsp valids stay 0 until LATENCY cycles after the first post-reset accept.

## Configuration
- Macro ROM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Port 0 always wins when both ports are valid. The `prio` register is not built. Port 1 is granted only when req0_valid = 0.
- Undefined (default): round-robin as described under Arbitration.

## Test plan
1. Single port, LATENCY=2, ROM loaded with data[i] = i ^ 16'hA5A5:
   - Stimulus: port 0 reads address 5.
   - Required: req0_ready = 1 in cycle 0, rsp0_valid = 1 in cycle 2 with rsp0_data = 16'hA5A0, rsp1_valid = 0 throughout.
2. Contention:
   - Stimulus: both ports valid continuously for 6 cycles; port 0 at address 0x10, port 1 at 0x20.
   - Required: grants 0,1,0,1,0,1; responses arrive 2 cycles later alternating rsp0/rsp1 with the matching data.
3. Streaming:
   - Stimulus: port 1 alone issues addresses 100..107 on consecutive cycles.
   - Required: rsp1_valid is high for 8 consecutive cycles, with data for 100..107 in order.
4. Reset mid-flight:
   - Stimulus: assert rst one cycle after port 0 is accepted.
   - Required: rsp0_valid never rises for that read; `prio` = 0; the next contention is won by port 0.
5. LATENCY=1, ROM in LOW_LATENCY mode:
   - Stimulus: port 0 reads address 3.
   - Required: rsp0_valid is high in cycle 1 with the data for address 3.
6. ROM_ARB_FIXED_PRIO_EN defined:
   - Stimulus: both ports valid for 4 cycles, then port 0 drops its request.
   - Required: port 0 is granted 4 times, then port 1 is granted in cycle 4.
